// File: rtl/ele_pkg.sv
// Shared types and constants for the cabin motion and door sequencer.
package ele_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        ARRIVE    = 3'd3,
        DOOR      = 3'd4
    } state_t;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;

    localparam logic [3:0] FLOOR1 = 4'b0001;
    localparam logic [3:0] FLOOR2 = 4'b0010;
    localparam logic [3:0] FLOOR3 = 4'b0100;
    localparam logic [3:0] FLOOR4 = 4'b1000;

    // Binary index of a one-hot floor vector; non-one-hot input maps to 0.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            FLOOR2:  idx = 2'd1;
            FLOOR3:  idx = 2'd2;
            FLOOR4:  idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Counter width wide enough to hold the larger of the two terminal values.
    function automatic int cnt_width(input int a, input int b);
        return (a > b) ? $clog2(a) : $clog2(b);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Up-counting tick timer with synchronous clear and terminal-count compare.
// Shared between the travel and door phases; the caller selects tc_val.
module tick_timer
    import ele_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] count;

    // Terminal count is a plain compare against the selected limit.
    always_comb begin
        tc = (count == tc_val);
    end

    // Count holds at terminal value so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ele_motion_ctrl.sv
// Cabin motion and door sequencer. Consumes run mode and pending requests,
// produces the one-hot cabin position plus door and motion status.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | parked at a floor, door closed, waiting for request or mode
// MOVE_UP   | travelling one floor up, timer counts MOVE_TICKS
// MOVE_DOWN | travelling one floor down, timer counts MOVE_TICKS
// ARRIVE    | one cycle at the new floor so the request logic sees it
// DOOR      | door open, timer counts DOOR_TICKS, door_hold restarts it
module ele_motion_ctrl
    import ele_pkg::*;
#(
    parameter int MOVE_TICKS = 64,
    parameter int DOOR_TICKS = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ud_mode,
    input  logic [3:0] all_req,
    input  logic       door_hold,
    output logic [3:0] position,
    output logic [1:0] floor_num,
    output logic       door_open,
    output logic       moving,
    output logic [1:0] dir,
    output logic       arrive
);

    localparam int CW = cnt_width(MOVE_TICKS, DOOR_TICKS);
    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);

    state_t        state;
    state_t        dispatch;
    logic          tmr_clr;
    logic          tmr_en;
    logic          tmr_tc;
    logic [CW-1:0] tmr_tc_val;
    logic [3:0]    pos_up;
    logic [3:0]    pos_dn;

    tick_timer #(
        .W(CW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .tc_val (tmr_tc_val),
        .tc     (tmr_tc)
    );

    // Timer runs only in timed states; every other state leaves it cleared,
    // which gives the clear-on-entry behaviour for free.
    always_comb begin
        tmr_en     = (state == MOVE_UP) || (state == MOVE_DOWN) || (state == DOOR);
        tmr_clr    = !tmr_en || ((state == DOOR) && door_hold);
        tmr_tc_val = (state == DOOR) ? DOOR_LAST : MOVE_LAST;
    end

    // Next-floor candidates; the end-floor guards keep these one-hot.
    always_comb begin
        pos_up = {position[2:0], 1'b0};
        pos_dn = {1'b0, position[3:1]};
    end

    // Decision shared by IDLE and ARRIVE: door first, then up, then down.
    // Mode 11 matches neither direction and so behaves as stop.
    always_comb begin
        dispatch = IDLE;
        if (((all_req & position) != 4'b0000) || door_hold) begin
            dispatch = DOOR;
        end else if ((ud_mode == MODE_UP) && (position != FLOOR4)) begin
            dispatch = MOVE_UP;
        end else if ((ud_mode == MODE_DOWN) && (position != FLOOR1)) begin
            dispatch = MOVE_DOWN;
        end
    end

    // Main sequencer with registered position, floor index, door and arrive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            position  <= FLOOR1;
            floor_num <= 2'd0;
            door_open <= 1'b0;
            arrive    <= 1'b0;
        end else begin
            arrive <= 1'b0;
            case (state)
                IDLE, ARRIVE: begin
                    state     <= dispatch;
                    door_open <= (dispatch == DOOR);
                end
                MOVE_UP: begin
                    if (tmr_tc) begin
                        position  <= pos_up;
                        floor_num <= onehot_to_idx(pos_up);
                        arrive    <= 1'b1;
                        state     <= ARRIVE;
                    end
                end
                MOVE_DOWN: begin
                    if (tmr_tc) begin
                        position  <= pos_dn;
                        floor_num <= onehot_to_idx(pos_dn);
                        arrive    <= 1'b1;
                        state     <= ARRIVE;
                    end
                end
                DOOR: begin
                    if (tmr_tc && !door_hold) begin
                        door_open <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    door_open <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Motion status decodes straight from state so it tracks it exactly.
    always_comb begin
        moving = (state == MOVE_UP) || (state == MOVE_DOWN);
        dir    = DIR_NONE;
        if (state == MOVE_UP) begin
            dir = DIR_UP;
        end else if (state == MOVE_DOWN) begin
            dir = DIR_DOWN;
        end
    end

    a_pos_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot(position));

    a_no_shift_above_top: assert property (@(posedge clk) disable iff (rst)
        (state == MOVE_UP) |-> (position != FLOOR4));

    a_no_shift_below_bottom: assert property (@(posedge clk) disable iff (rst)
        (state == MOVE_DOWN) |-> (position != FLOOR1));

endmodule

// File: tb/tb_ele_motion_ctrl.sv
// Self-checking bench for ele_motion_ctrl with an arrival scoreboard.
module tb_ele_motion_ctrl;

    localparam int MT = 4;
    localparam int DT = 3;

    logic       clk;
    logic       rst;
    logic [1:0] ud_mode;
    logic [3:0] all_req;
    logic       door_hold;
    logic [3:0] position;
    logic [1:0] floor_num;
    logic       door_open;
    logic       moving;
    logic [1:0] dir;
    logic       arrive;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {floor_num, position} for each arrival, in order.
    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;

    ele_motion_ctrl #(
        .MOVE_TICKS(MT),
        .DOOR_TICKS(DT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ud_mode   (ud_mode),
        .all_req   (all_req),
        .door_hold (door_hold),
        .position  (position),
        .floor_num (floor_num),
        .door_open (door_open),
        .moving    (moving),
        .dir       (dir),
        .arrive    (arrive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every arrival pulse must match the next expected floor.
    always @(negedge clk) begin
        if (!rst && arrive) begin
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL arrive_unexpected: got pos=%b num=%0d, required no arrival", position, floor_num);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({floor_num, position} !== mon_exp) begin
                    n_fail = n_fail + 1;
                    $display("FAIL arrive_floor: got num=%0d pos=%b, required num=%0d pos=%b",
                             floor_num, position, mon_exp[5:4], mon_exp[3:0]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ud_mode = 2'b00; all_req = 4'b0000; door_hold = 1'b0;
        tick(); tick();
        n_checks++; if (position !== 4'b0001) begin n_fail++; $display("FAIL reset_position: got %b, required 0001", position); end
        n_checks++; if (floor_num !== 2'd0) begin n_fail++; $display("FAIL reset_floor_num: got %0d, required 0", floor_num); end
        n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL reset_door_open: got %b, required 0", door_open); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b, required 0", moving); end
        n_checks++; if (dir !== 2'b00) begin n_fail++; $display("FAIL reset_dir: got %b, required 00", dir); end
        n_checks++; if (arrive !== 1'b0) begin n_fail++; $display("FAIL reset_arrive: got %b, required 0", arrive); end
        rst = 1'b0;
        tick();
    endtask

    // Floor 1 -> floor 3 with a request at floor 3, then door cycle.
    task automatic test_travel_up();
        int mv = 0, dr = 0, ar = 0, dir_err = 0;
        bit opened = 0, done = 0;
        logic [3:0] door_pos = 4'b0000;
        ud_mode = 2'b01; all_req = 4'b0100;
        exp_q.push_back({2'd1, 4'b0010});
        exp_q.push_back({2'd2, 4'b0100});
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (moving) begin
                mv++;
                if (dir !== 2'b01) dir_err++;
            end else if (dir !== 2'b00) dir_err++;
            if (arrive) ar++;
            if (door_open) begin
                dr++;
                if (!opened) begin
                    opened = 1; door_pos = position;
                    all_req = 4'b0000; ud_mode = 2'b00;
                end
            end else if (opened) done = 1;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL travel_up_timeout: got no door close, required close within 40 cycles"); end
        n_checks++; if (mv != 2 * MT) begin n_fail++; $display("FAIL travel_up_moving_cycles: got %0d, required %0d", mv, 2 * MT); end
        n_checks++; if (ar != 2) begin n_fail++; $display("FAIL travel_up_arrive_count: got %0d, required 2", ar); end
        n_checks++; if (dr != DT) begin n_fail++; $display("FAIL travel_up_door_cycles: got %0d, required %0d", dr, DT); end
        n_checks++; if (door_pos !== 4'b0100) begin n_fail++; $display("FAIL travel_up_door_floor: got %b, required 0100", door_pos); end
        n_checks++; if (dir_err != 0) begin n_fail++; $display("FAIL travel_up_dir: got %0d bad samples, required 0", dir_err); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL travel_up_idle: got moving=%b, required 0", moving); end
    endtask

    // Floor 3 -> floor 4, then up mode held at the top floor.
    task automatic test_top_floor();
        int mv = 0;
        bit got = 0;
        ud_mode = 2'b01; all_req = 4'b0000;
        exp_q.push_back({2'd3, 4'b1000});
        for (int i = 0; i < 30; i++) begin
            tick();
            if (moving) mv++;
            if (arrive) got = 1;
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL top_floor_arrive: got no arrival, required arrival at floor 4"); end
        n_checks++; if (mv != MT) begin n_fail++; $display("FAIL top_floor_moving_cycles: got %0d, required %0d", mv, MT); end
        n_checks++; if (position !== 4'b1000) begin n_fail++; $display("FAIL top_floor_position: got %b, required 1000", position); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL top_floor_moving: got %b, required 0", moving); end
    endtask

    // Go down to floor 2, then hold the door while down mode is requested.
    task automatic test_door_hold();
        int dr = 0, mv_in_door = 0;
        bit opened = 0, done = 0, got = 0;
        ud_mode = 2'b10; all_req = 4'b0010;
        exp_q.push_back({2'd2, 4'b0100});
        exp_q.push_back({2'd1, 4'b0010});
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (door_open && !opened) begin
                opened = 1; all_req = 4'b0000; ud_mode = 2'b00;
            end else if (!door_open && opened) done = 1;
        end
        n_checks++; if (!done || position !== 4'b0010) begin n_fail++; $display("FAIL hold_setup: got done=%b pos=%b, required 1 and 0010", done, position); end

        door_hold = 1'b1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (door_open) begin
                dr++;
                if (moving) mv_in_door++;
                if (dr == 1) begin
                    ud_mode = 2'b10;
                    exp_q.push_back({2'd0, 4'b0001});
                end
                if (dr == 11) door_hold = 1'b0;
            end else if (dr > 0) done = 1;
        end
        door_hold = 1'b0;
        n_checks++; if (dr != 10 + DT) begin n_fail++; $display("FAIL hold_door_cycles: got %0d, required %0d", dr, 10 + DT); end
        n_checks++; if (mv_in_door != 0) begin n_fail++; $display("FAIL hold_motion_in_door: got %0d, required 0", mv_in_door); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL hold_close_moving: got %b, required 0", moving); end
        tick();
        n_checks++; if (moving !== 1'b1 || dir !== 2'b10) begin n_fail++; $display("FAIL hold_then_down: got moving=%b dir=%b, required 1 10", moving, dir); end
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (arrive) got = 1;
        end
        ud_mode = 2'b00;
        n_checks++; if (!got) begin n_fail++; $display("FAIL hold_down_arrive: got no arrival, required floor 1"); end
        tick();
    endtask

    // Mode flipped to down two cycles into an up trip: finish, then return.
    task automatic test_reversal();
        int mv = 0, got = 0;
        ud_mode = 2'b01;
        exp_q.push_back({2'd1, 4'b0010});
        exp_q.push_back({2'd0, 4'b0001});
        for (int i = 0; i < 30 && got < 1; i++) begin
            tick();
            if (moving) begin
                mv++;
                if (mv == 2) ud_mode = 2'b10;
            end
            if (arrive) got++;
        end
        n_checks++; if (position !== 4'b0010) begin n_fail++; $display("FAIL reversal_first_floor: got %b, required 0010", position); end
        tick();
        n_checks++; if (moving !== 1'b1 || dir !== 2'b10) begin n_fail++; $display("FAIL reversal_dir: got moving=%b dir=%b, required 1 10", moving, dir); end
        for (int i = 0; i < 20 && got < 2; i++) begin
            tick();
            if (arrive) got++;
        end
        ud_mode = 2'b00;
        n_checks++; if (got != 2) begin n_fail++; $display("FAIL reversal_arrivals: got %0d, required 2", got); end
        tick();
    endtask

    // Mode 11 acts as stop; a request at the current floor opens the door.
    task automatic test_mode11();
        int mv = 0;
        bit done = 0;
        ud_mode = 2'b11; all_req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (moving) mv++;
        end
        n_checks++; if (mv != 0 || position !== 4'b0001) begin n_fail++; $display("FAIL mode11_stop: got moving_cycles=%0d pos=%b, required 0 0001", mv, position); end
        all_req = 4'b0001;
        tick();
        n_checks++; if (door_open !== 1'b1) begin n_fail++; $display("FAIL mode11_door: got door_open=%b, required 1", door_open); end
        all_req = 4'b0000; ud_mode = 2'b00;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (!door_open) done = 1;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL mode11_door_close: got door still open, required closed"); end
    endtask

    // Asynchronous reset applied mid-travel between floor 2 and floor 3.
    task automatic test_async_reset();
        int stray = 0;
        bit got = 0;
        ud_mode = 2'b01;
        exp_q.push_back({2'd1, 4'b0010});
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (arrive) got = 1;
        end
        tick(); tick();
        n_checks++; if (moving !== 1'b1 || position !== 4'b0010) begin n_fail++; $display("FAIL areset_setup: got moving=%b pos=%b, required 1 0010", moving, position); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (position !== 4'b0001) begin n_fail++; $display("FAIL areset_position: got %b, required 0001", position); end
        n_checks++; if (door_open !== 1'b0 || moving !== 1'b0) begin n_fail++; $display("FAIL areset_status: got door=%b moving=%b, required 0 0", door_open, moving); end
        n_checks++; if (floor_num !== 2'd0 || arrive !== 1'b0 || dir !== 2'b00) begin n_fail++; $display("FAIL areset_misc: got num=%0d arrive=%b dir=%b, required 0 0 00", floor_num, arrive, dir); end
        ud_mode = 2'b00;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (arrive || moving || position !== 4'b0001) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL areset_residual: got %0d bad samples, required 0", stray); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_travel_up();
        test_top_floor();
        test_door_hold();
        test_reversal();
        test_mode11();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending arrivals, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
